lane_shift_register: RTL and testbench
======================================

Name: lane_shift_register

Overview:
Parametrised successor to the fixed 4-bit D-flip-flop register: a DEPTH-stage by WIDTH-bit shift register for scrolling note lanes. It steps on an enable strobe, supports hold/shift/rotate/clear modes, and exposes all stages for the display path. It also resolves player key presses against the bottom stage and counts hits and misses. It sits between the note-pattern source and the VGA/score logic.

Parameters:
WIDTH, 4, bits per stage (one bit per finger lane)
DEPTH, 8, number of stages; stage 0 is the top (entry), stage DEPTH-1 is the bottom (judgement row)
CNTW, 8, width of the hit and miss counters

Ports:
C  input  1  clock; all state updates on the rising edge
R  input  1  reset, asynchronous, active-high
E  input  1  step strobe; the mode in M applies only on cycles with E=1
M  input  2  mode: 00 hold, 01 shift, 10 rotate, 11 clear
I  input  WIDTH  new row loaded into stage 0 on shift
H  input  WIDTH  key-press pulses, one bit per lane, single-cycle, from the upstream edge detector
O  output  WIDTH  bottom stage (stage DEPTH-1) contents
T  output  DEPTH*WIDTH  all stages flattened; stage k at bits [k*WIDTH +: WIDTH]
HIT  output  1  one-cycle pulse: at least one pressed lane matched a set bit in the bottom stage
MISS  output  1  one-cycle pulse: a shift discarded a bottom row with unmatched bits
HITCNT  output  CNTW  saturating count of HIT cycles
MISSCNT  output  CNTW  saturating count of MISS cycles

Behaviour:
- Reset (asynchronous, R=1): all stages 0; HIT=0; MISS=0; HITCNT=0; MISSCNT=0. Reset asserted mid-operation overrides everything immediately.
- All outputs are registered. O and T reflect state after the edge, so latency is 1 cycle from the E strobe.
- Hit resolution runs every cycle, independent of E and M:
  - match = H & stage[DEPTH-1]
  - HIT=1 on the next cycle iff match is nonzero
  - matched bits are cleared in the bottom row, so holding H cannot double-count
- E=0, or M=00 (hold): stages unchanged, except the hit clear on the bottom stage.
- M=01 (shift):
  - stage[0]<=I; stage[k]<=stage[k-1]
  - outgoing = stage[DEPTH-1] & ~H, i.e. the hit is evaluated on the pre-shift bottom row in the same cycle
  - MISS=1 iff outgoing is nonzero; the outgoing row is discarded
- M=10 (rotate):
  - stage[0]<=stage[DEPTH-1] & ~H; the others shift as in M=01
  - I is ignored; MISS is never asserted
- M=11 (clear): all stages <=0; MISS=0; HIT is still evaluated on the pre-clear bottom row. Counters are not cleared.
- Counters:
  - HITCNT increments by 1 on each cycle HIT is asserted; MISSCNT likewise for MISS
  - both saturate at 2^CNTW-1 and never wrap
- HIT and MISS may both assert in the same cycle, e.g. a partial match on a shifted row.
- DEPTH=1 is legal: stage 0 is also the bottom stage, shift loads I directly, and the miss/hit rules are unchanged.
- Parameters require WIDTH>=1, DEPTH>=1, CNTW>=1; the design is synthesisable with no latches.

Decomposition:
- Shared package holds:
  - mode constants MODE_HOLD=2'b00, MODE_SHIFT=2'b01, MODE_ROTATE=2'b10, MODE_CLEAR=2'b11
  - a saturating-increment function reused by the score logic
- One sub-module, register_nbit (parameter N): N-bit register with clock C, asynchronous active-high R, and load enable L. Instantiate it DEPTH times through a generate loop.
- Hit/miss logic and the counters stay in the top module.

Test Plan:
- Reset check: assert R mid-shift with stages nonzero -> all outputs 0 within the same cycle, with no clock edge needed.
- Shift fill (WIDTH=4, DEPTH=8): apply I=4'b0001..4'b1000 over 8 E=1/M=01 strobes -> T stages hold rows in reverse order, O=4'b0001; no MISS since every row shifted out was 0.
- Miss and partial hit:
  - bottom row 4'b1010 with no H on a shift -> MISS=1 and MISSCNT=1
  - bottom row 4'b1010 with H=4'b1000 on a shift -> HIT=1 and MISS=1 in the same cycle, both counters +1
- Full hit without step: bottom row 4'b0110, E=0, H=4'b0110 -> HIT=1, O=0 next cycle; H held for 3 more cycles -> HITCNT rises by exactly 1.
- Rotate and clear:
  - 8 rotate strobes -> T returns to its original value, MISS never asserts
  - M=11 -> T=0, counters retained
- Saturation (CNTW=2): force 5 misses -> MISSCNT stays at 3.

Source files
------------

// File: rtl/lane_shift_register_pkg.sv
// Shared definitions for the note-lane shift register: step modes and
// the saturating increment used by the hit/miss score counters.
package lane_shift_register_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SHIFT  = 2'b01,
        MODE_ROTATE = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_t;

    // Increments value, sticking at the all-ones value of a width-bit counter (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max;
        max = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value == max) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/lane_shift_register_register.sv
// Plain N-bit storage register with asynchronous active-high reset and load enable.
module register_nbit #(
    parameter int unsigned N = 4
) (
    input  logic         C,
    input  logic         R,
    input  logic         L,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q
);

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            Q <= '0;
        end else if (L) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/lane_shift_register.sv
// DEPTH x WIDTH scrolling note-lane register with key-press hit resolution
// against the bottom row and saturating hit/miss counters.
module lane_shift_register
    import lane_shift_register_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNTW  = 8
) (
    input  logic                   C,
    input  logic                   R,
    input  logic                   E,
    input  logic [1:0]             M,
    input  logic [WIDTH-1:0]       I,
    input  logic [WIDTH-1:0]       H,
    output logic [WIDTH-1:0]       O,
    output logic [DEPTH*WIDTH-1:0] T,
    output logic                   HIT,
    output logic                   MISS,
    output logic [CNTW-1:0]        HITCNT,
    output logic [CNTW-1:0]        MISSCNT
);

    logic [WIDTH-1:0] stage      [DEPTH];
    logic [WIDTH-1:0] stage_next [DEPTH];
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] bottom;
    logic [WIDTH-1:0] match;
    logic [WIDTH-1:0] residual;
    logic             hit_next;
    logic             miss_next;
    mode_t            mode;

    always_comb begin
        mode     = E ? mode_t'(M) : MODE_HOLD;
        bottom   = stage[DEPTH-1];
        match    = H & bottom;
        residual = bottom & ~H;
        hit_next  = |match;
        miss_next = 1'b0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            stage_next[k] = stage[k];
            load[k]       = 1'b0;
        end
        // Matched bits leave the bottom row every cycle, whatever the mode.
        stage_next[DEPTH-1] = residual;
        load[DEPTH-1]       = |match;
        case (mode)
            MODE_SHIFT, MODE_ROTATE: begin
                for (int unsigned k = DEPTH - 1; k >= 1; k--) begin
                    stage_next[k] = stage[k-1];
                end
                // Assigned last so DEPTH=1 takes the entry row rather than the residual.
                stage_next[0] = (mode == MODE_SHIFT) ? I : residual;
                load          = '1;
                miss_next     = (mode == MODE_SHIFT) && (|residual);
            end
            MODE_CLEAR: begin
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    stage_next[k] = '0;
                end
                load = '1;
            end
            default: ;
        endcase
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        register_nbit #(.N(WIDTH)) u_reg (
            .C(C),
            .R(R),
            .L(load[k]),
            .D(stage_next[k]),
            .Q(stage[k])
        );
        assign T[k*WIDTH +: WIDTH] = stage[k];
    end

    assign O = stage[DEPTH-1];

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            HIT     <= 1'b0;
            MISS    <= 1'b0;
            HITCNT  <= '0;
            MISSCNT <= '0;
        end else begin
            HIT  <= hit_next;
            MISS <= miss_next;
            if (hit_next) begin
                HITCNT <= CNTW'(sat_inc(32'(HITCNT), CNTW));
            end
            if (miss_next) begin
                MISSCNT <= CNTW'(sat_inc(32'(MISSCNT), CNTW));
            end
        end
    end

endmodule

// File: tb/tb_lane_shift_register.sv
// Bench: an 8-deep lane and a 1-deep lane with 2-bit counters share one
// stimulus stream; both are checked every cycle against a vector-arithmetic model.
module tb_lane_shift_register;

    logic        C = 1'b0;
    logic        R = 1'b1;
    logic        E = 1'b0;
    logic [1:0]  M = 2'b00;
    logic [3:0]  I = 4'h0;
    logic [3:0]  H = 4'h0;

    logic [3:0]  o1;
    logic [31:0] t1;
    logic        hit1, miss1;
    logic [7:0]  hc1, mc1;

    logic [3:0]  o2;
    logic [3:0]  t2;
    logic        hit2, miss2;
    logic [1:0]  hc2, mc2;

    int total = 0;
    int bad   = 0;

    logic [31:0] mv1 = '0;
    logic [31:0] mv2 = '0;
    int          mh1 = 0, mm1 = 0, mh2 = 0, mm2 = 0;
    bit          eh1 = 0, em1 = 0, eh2 = 0, em2 = 0;

    lane_shift_register #(.WIDTH(4), .DEPTH(8), .CNTW(8)) dut (
        .C(C), .R(R), .E(E), .M(M), .I(I), .H(H),
        .O(o1), .T(t1), .HIT(hit1), .MISS(miss1), .HITCNT(hc1), .MISSCNT(mc1)
    );

    lane_shift_register #(.WIDTH(4), .DEPTH(1), .CNTW(2)) dut_small (
        .C(C), .R(R), .E(E), .M(M), .I(I), .H(H),
        .O(o2), .T(t2), .HIT(hit2), .MISS(miss2), .HITCNT(hc2), .MISSCNT(mc2)
    );

    always #5 C = ~C;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane held as one vector, stage k in nibble k; the bottom row is the top nibble in use.
    task automatic mstep(input int depth, input int cmax, inout logic [31:0] v,
                         inout int hc, inout int mc, output bit hit, output bit miss);
        int          sh;
        logic [31:0] mask;
        logic [3:0]  bot;
        logic [3:0]  res;
        logic [1:0]  mode;
        sh   = 4 * (depth - 1);
        mask = (depth == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * depth)) - 32'd1);
        bot  = 4'(v >> sh);
        res  = bot & ~H;
        hit  = (bot & H) != 4'h0;
        miss = 1'b0;
        mode = E ? M : 2'b00;
        case (mode)
            2'b00: v = v & ~(32'(bot & H) << sh);
            2'b01: begin
                miss = res != 4'h0;
                v = ((v << 4) | 32'(I)) & mask;
            end
            2'b10: v = ((v << 4) | 32'(res)) & mask;
            default: v = '0;
        endcase
        if (hit && hc < cmax) hc++;
        if (miss && mc < cmax) mc++;
    endtask

    always @(posedge C or posedge R) begin
        if (R) begin
            mv1 = '0; mv2 = '0;
            mh1 = 0; mm1 = 0; mh2 = 0; mm2 = 0;
            eh1 = 0; em1 = 0; eh2 = 0; em2 = 0;
        end else begin
            mstep(8, 255, mv1, mh1, mm1, eh1, em1);
            mstep(1, 3, mv2, mh2, mm2, eh2, em2);
        end
    end

    always @(negedge C) begin
        chk("t_deep",     t1, mv1);
        chk("o_deep",     32'(o1), 32'(mv1[31:28]));
        chk("hit_deep",   32'(hit1), 32'(eh1));
        chk("miss_deep",  32'(miss1), 32'(em1));
        chk("hcnt_deep",  32'(hc1), mh1);
        chk("mcnt_deep",  32'(mc1), mm1);
        chk("t_small",    32'(t2), 32'(mv2[3:0]));
        chk("o_small",    32'(o2), 32'(mv2[3:0]));
        chk("hit_small",  32'(hit2), 32'(eh2));
        chk("miss_small", 32'(miss2), 32'(em2));
        chk("hcnt_small", 32'(hc2), mh2);
        chk("mcnt_small", 32'(mc2), mm2);
    end

    task automatic step(input logic e, input logic [1:0] m, input logic [3:0] i, input logic [3:0] h);
        @(negedge C);
        E = e; M = m; I = i; H = h;
        @(posedge C);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge C);
        @(negedge C);
        R = 1'b0;
        #1;
        chk("rst_t", t1, 32'h0);
        chk("rst_cnt", 32'(hc1), 32'h0);

        for (int k = 0; k < 8; k++) step(1'b1, 2'b01, 4'(k + 1), 4'h0);
        chk("fill_t", t1, 32'h1234_5678);
        chk("fill_o", 32'(o1), 32'h1);
        chk("fill_mcnt", 32'(mc1), 32'h0);
        chk("small_sat", 32'(mc2), 32'h3);
        chk("small_t", 32'(t2), 32'h8);

        step(1'b1, 2'b11, 4'h0, 4'h0);
        step(1'b1, 2'b01, 4'b1010, 4'h0);
        step(1'b1, 2'b01, 4'b1010, 4'h0);
        repeat (6) step(1'b1, 2'b01, 4'h0, 4'h0);
        chk("miss_setup_o", 32'(o1), 32'hA);
        step(1'b1, 2'b01, 4'h0, 4'h0);
        chk("miss_pulse", 32'(miss1), 32'h1);
        chk("miss_nohit", 32'(hit1), 32'h0);
        chk("miss_cnt", 32'(mc1), 32'h1);
        step(1'b1, 2'b01, 4'h0, 4'b1000);
        chk("partial_hit", 32'(hit1), 32'h1);
        chk("partial_miss", 32'(miss1), 32'h1);
        chk("partial_hcnt", 32'(hc1), 32'h1);
        chk("partial_mcnt", 32'(mc1), 32'h2);

        step(1'b1, 2'b11, 4'h0, 4'h0);
        step(1'b1, 2'b01, 4'b0110, 4'h0);
        repeat (7) step(1'b1, 2'b01, 4'h0, 4'h0);
        chk("full_setup_o", 32'(o1), 32'h6);
        step(1'b0, 2'b00, 4'h0, 4'b0110);
        chk("full_hit", 32'(hit1), 32'h1);
        chk("full_o", 32'(o1), 32'h0);
        chk("full_hcnt", 32'(hc1), 32'h2);
        repeat (3) step(1'b0, 2'b01, 4'h0, 4'b0110);
        chk("held_hcnt", 32'(hc1), 32'h2);
        chk("held_hit", 32'(hit1), 32'h0);

        step(1'b1, 2'b11, 4'h0, 4'h0);
        for (int k = 0; k < 8; k++) step(1'b1, 2'b01, 4'(k + 1), 4'h0);
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 2'b10, 4'($urandom), 4'h0);
            chk("rot_nomiss", 32'(miss1), 32'h0);
        end
        chk("rot_t", t1, 32'h1234_5678);
        step(1'b1, 2'b11, 4'h0, 4'h0);
        chk("clr_t", t1, 32'h0);
        chk("clr_hcnt", 32'(hc1), 32'h2);
        chk("clr_mcnt", 32'(mc1), 32'h2);

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom),
                 ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
        end

        step(1'b1, 2'b01, 4'hF, 4'h0);
        chk("pre_rst_t", 32'(t1[3:0]), 32'hF);
        #1 R = 1'b1;
        #1;
        chk("async_t", t1, 32'h0);
        chk("async_o", 32'(o1), 32'h0);
        chk("async_flags", {30'h0, hit1, miss1}, 32'h0);
        chk("async_cnts", {16'h0, hc1, mc1}, 32'h0);
        @(posedge C);
        @(negedge C);
        R = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step(1'b1, 2'($urandom), 4'($urandom), 4'($urandom));
        end

        @(negedge C);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
